// File: rtl/cic_ctrl_pkg.sv
// Shared types and sizing helpers for the CIC decimator controller.
package cic_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } cic_state_t;

  // One extra bit so that R_MAX itself is representable.
  function automatic int rate_width(input int r_max);
    return $clog2(r_max) + 1;
  endfunction

  function automatic int flush_cycles(input int n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/cic_out_fifo.sv
// Output sample buffer: power-of-2 synchronous FIFO whose pointers carry an
// extra wrap bit to tell full from empty.
module cic_out_fifo #(
  parameter int DATA_WIDTH = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear && (!full || do_pop);
  assign drop    = push && !clear && full && !do_pop;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// Run-time controller for the CIC decimator: restart sequencing, decimation
// strobe, start-up transient discard and buffered valid/ready output.
module cic_decim_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int  N          = 2,
  parameter int  R_MAX      = 256,
  parameter int  R_DEFAULT  = 16,
  parameter int  DATA_WIDTH = 14,
  parameter int  FIFO_DEPTH = 4,
  localparam int RW         = rate_width(R_MAX)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  rate_wr,
  input  logic [RW-1:0]         rate_in,
  output logic                  rate_ack,
  output logic                  rate_err,
  output logic [RW-1:0]         cic_rate,
  output logic                  cic_clr,
  output logic                  cic_stb,
  input  logic [DATA_WIDTH-1:0] cic_data,
  input  logic                  cic_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [1:0]            state
);

  localparam int FLUSH_CYC = flush_cycles(N);
  localparam int FCW       = $clog2(FLUSH_CYC);
  localparam int DCW       = (N > 1) ? $clog2(N) : 1;

  cic_state_t     cur_state;
  cic_state_t     next_state;
  logic [FCW-1:0] flush_cnt;
  logic [DCW-1:0] discard_cnt;
  logic [RW-1:0]  phase;

  logic rate_ok;
  logic enter_flush;
  logic flush_done;
  logic settle_done;
  logic counting;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_drop;
  logic ovf_set;

  assign rate_ok     = rate_wr && (rate_in >= RW'(2)) && (rate_in <= RW'(R_MAX));
  assign flush_done  = (flush_cnt == FCW'(FLUSH_CYC - 1));
  assign settle_done = cic_valid && (discard_cnt == DCW'(N - 1));
  assign enter_flush = (next_state == ST_FLUSH) && ((cur_state != ST_FLUSH) || rate_ok);
  assign state       = cur_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= ST_IDLE;
    else        cur_state <= next_state;
  end

  // Disable overrides everything; a valid rate write outside IDLE restarts the flush.
  always_comb begin
    next_state = cur_state;
    if (!enable) begin
      next_state = ST_IDLE;
    end else begin
      unique case (cur_state)
        ST_IDLE:   next_state = ST_FLUSH;
        ST_FLUSH:  if (rate_ok)          next_state = ST_FLUSH;
                   else if (flush_done)  next_state = ST_SETTLE;
        ST_SETTLE: if (rate_ok)          next_state = ST_FLUSH;
                   else if (settle_done) next_state = ST_RUN;
        ST_RUN:    if (rate_ok)          next_state = ST_FLUSH;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cic_clr   = 1'b0;
    counting  = 1'b0;
    cic_stb   = 1'b0;
    fifo_push = 1'b0;
    unique case (cur_state)
      ST_IDLE, ST_FLUSH: cic_clr = 1'b1;
      ST_SETTLE:         counting = 1'b1;
      ST_RUN: begin
        counting  = 1'b1;
        fifo_push = cic_valid;
      end
      default:           cic_clr = 1'b1;
    endcase
    cic_stb = counting && (phase == cic_rate - RW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (enter_flush) begin
      flush_cnt <= '0;
    end else if (cur_state == ST_FLUSH && !flush_done) begin
      flush_cnt <= flush_cnt + FCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard_cnt <= '0;
    end else if (enter_flush) begin
      discard_cnt <= '0;
    end else if (cur_state == ST_SETTLE && cic_valid && !settle_done) begin
      discard_cnt <= discard_cnt + DCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (enter_flush || !counting) begin
      phase <= '0;
    end else if (phase >= cic_rate - RW'(1)) begin
      phase <= '0;
    end else begin
      phase <= phase + RW'(1);
    end
  end

  // Every valid write lands on an edge that either stays in IDLE or enters FLUSH,
  // so the pending rate is applied at that same edge and never outlives a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cic_rate <= RW'(R_DEFAULT);
      rate_ack <= 1'b0;
      rate_err <= 1'b0;
    end else begin
      rate_ack <= rate_ok;
      rate_err <= rate_wr && !rate_ok;
      if (rate_ok) cic_rate <= rate_in;
    end
  end

  assign m_valid  = !fifo_empty;
  assign fifo_pop = m_valid && m_ready;
  assign ovf_set  = fifo_drop && fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  cic_out_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (enter_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (cic_data),
    .dout  (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl: expected samples go into a queue when issued
// and a negedge monitor compares them as the FIFO hands them out.
module tb_cic_decim_ctrl;

  localparam int N          = 2;
  localparam int R_MAX      = 256;
  localparam int R_DEFAULT  = 16;
  localparam int DATA_WIDTH = 14;
  localparam int FIFO_DEPTH = 4;
  localparam int RW         = 9;

  logic                  clk       = 1'b0;
  logic                  clk_run   = 1'b1;
  logic                  rst_n     = 1'b0;
  logic                  enable    = 1'b0;
  logic                  rate_wr   = 1'b0;
  logic [RW-1:0]         rate_in   = '0;
  logic                  rate_ack;
  logic                  rate_err;
  logic [RW-1:0]         cic_rate;
  logic                  cic_clr;
  logic                  cic_stb;
  logic [DATA_WIDTH-1:0] cic_data  = '0;
  logic                  cic_valid = 1'b0;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready   = 1'b1;
  logic                  overflow;
  logic                  ovf_clr   = 1'b0;
  logic [1:0]            state;

  int                    errors = 0;
  int                    checks = 0;
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic [DATA_WIDTH-1:0] mon_exp;

  always #5 if (clk_run) clk = ~clk;

  cic_decim_ctrl #(
    .N          (N),
    .R_MAX      (R_MAX),
    .R_DEFAULT  (R_DEFAULT),
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .rate_wr   (rate_wr),
    .rate_in   (rate_in),
    .rate_ack  (rate_ack),
    .rate_err  (rate_err),
    .cic_rate  (cic_rate),
    .cic_clr   (cic_clr),
    .cic_stb   (cic_stb),
    .cic_data  (cic_data),
    .cic_valid (cic_valid),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .state     (state)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle cic_valid pulse; samples the DUT should keep are queued for the monitor.
  task automatic applyStimulus(input logic [DATA_WIDTH-1:0] data, input bit expect_out);
    if (expect_out) exp_q.push_back(data);
    cic_valid = 1'b1;
    cic_data  = data;
    tick();
    cic_valid = 1'b0;
  endtask

  task automatic countFlush(input bit check_ack, output int n);
    n = 0;
    while (state == 2'd1 && n < 20) begin
      checkOutput("flush_clr", cic_clr, 1);
      if (check_ack) checkOutput("ack_pulse", rate_ack, (n == 0) ? 1 : 0);
      n++;
      tick();
    end
  endtask

  task automatic waitStrobe(output int cycles);
    cycles = 1;
    while (!cic_stb && cycles < 600) begin
      tick();
      cycles++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL fifo_unexpected: got %0h, required no output", m_data);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("fifo_order", m_data, mon_exp);
      end
    end
  end

  initial begin
    int n;
    int cyc;
    int strobes;

    #12;
    checkOutput("rst_state", state, 0);
    checkOutput("rst_clr", cic_clr, 1);
    checkOutput("rst_stb", cic_stb, 0);
    checkOutput("rst_rate", cic_rate, R_DEFAULT);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_ack_err", {rate_ack, rate_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Start-up: 6 flush cycles, first strobe on the 16th SETTLE cycle, two discards.
    enable = 1'b1;
    tick();
    checkOutput("flush_entry", state, 1);
    countFlush(1'b0, n);
    checkOutput("flush_len", n, 6);
    checkOutput("settle_state", state, 2);
    checkOutput("settle_clr", cic_clr, 0);
    waitStrobe(cyc);
    checkOutput("first_stb_16", cyc, 16);
    tick();
    waitStrobe(cyc);
    checkOutput("stb_period_16", cyc, 16);
    applyStimulus(14'h0111, 1'b0);
    checkOutput("discard1_state", state, 2);
    applyStimulus(14'h0222, 1'b0);
    checkOutput("run_state", state, 3);
    checkOutput("discard_empty", m_valid, 0);
    applyStimulus(14'h0333, 1'b1);
    checkOutput("push_latency", m_valid, 1);
    checkOutput("first_sample", m_data, 14'h0333);
    tick();
    checkOutput("popped_empty", m_valid, 0);

    // Invalid rates are rejected without disturbing the run.
    rate_wr = 1'b1;
    rate_in = 9'd1;
    tick();
    rate_wr = 1'b0;
    checkOutput("err_low", rate_err, 1);
    checkOutput("err_low_ack", rate_ack, 0);
    checkOutput("err_low_rate", cic_rate, 16);
    checkOutput("err_low_state", state, 3);
    tick();
    checkOutput("err_pulse", rate_err, 0);
    rate_wr = 1'b1;
    rate_in = 9'd257;
    tick();
    rate_wr = 1'b0;
    checkOutput("err_high", rate_err, 1);
    checkOutput("err_high_rate", cic_rate, 16);
    checkOutput("err_high_state", state, 3);
    tick();

    // Backpressure: four held, fifth dropped.
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) applyStimulus(DATA_WIDTH'(14'h0100 + i), i <= 4);
    checkOutput("ovf_set", overflow, 1);
    checkOutput("full_valid", m_valid, 1);
    checkOutput("full_head", m_data, 14'h0101);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("ovf_clr", overflow, 0);
    ovf_clr = 1'b1;
    applyStimulus(14'h01EE, 1'b0);
    ovf_clr = 1'b0;
    checkOutput("ovf_set_wins", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("ovf_clr2", overflow, 0);

    // Full FIFO with simultaneous push and pop, then drain.
    m_ready = 1'b1;
    applyStimulus(14'h0106, 1'b1);
    checkOutput("push_pop_full_ovf", overflow, 0);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("drain_done", exp_q.size(), 0);
    checkOutput("drain_empty", m_valid, 0);

    // Rate change in RUN flushes the FIFO and restarts at rate 32.
    m_ready = 1'b0;
    applyStimulus(14'h01A7, 1'b1);
    checkOutput("pre_flush_valid", m_valid, 1);
    rate_wr = 1'b1;
    rate_in = 9'd32;
    exp_q.delete();
    tick();
    rate_wr = 1'b0;
    checkOutput("reflush_state", state, 1);
    checkOutput("rate_applied", cic_rate, 32);
    checkOutput("fifo_emptied", m_valid, 0);
    countFlush(1'b1, n);
    checkOutput("reflush_len", n, 6);
    checkOutput("resettle_state", state, 2);
    waitStrobe(cyc);
    checkOutput("first_stb_32", cyc, 32);
    tick();
    waitStrobe(cyc);
    checkOutput("stb_period_32", cyc, 32);
    m_ready = 1'b1;
    applyStimulus(14'h02AA, 1'b0);
    applyStimulus(14'h02BB, 1'b0);
    checkOutput("rerun_state", state, 3);
    applyStimulus(14'h02CC, 1'b1);
    checkOutput("rerun_valid", m_valid, 1);
    checkOutput("rerun_sample", m_data, 14'h02CC);
    tick();

    // Asynchronous reset with the clock stopped.
    m_ready = 1'b0;
    applyStimulus(14'h03C3, 1'b1);
    @(negedge clk);
    clk_run = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("arst_state", state, 0);
    checkOutput("arst_clr", cic_clr, 1);
    checkOutput("arst_stb", cic_stb, 0);
    checkOutput("arst_rate", cic_rate, R_DEFAULT);
    checkOutput("arst_m_valid", m_valid, 0);
    checkOutput("arst_m_data", m_data, 0);
    enable = 1'b0;
    m_ready = 1'b1;
    #2;
    rst_n = 1'b1;
    clk_run = 1'b1;
    tick();

    // Disable mid-SETTLE returns to IDLE and stops strobes.
    enable = 1'b1;
    n = 0;
    while (state != 2'd2 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("settle_again", state, 2);
    repeat (3) tick();
    enable = 1'b0;
    tick();
    checkOutput("disable_idle", state, 0);
    checkOutput("disable_clr", cic_clr, 1);
    strobes = 0;
    repeat (40) begin
      tick();
      if (cic_stb) strobes++;
    end
    checkOutput("idle_no_stb", strobes, 0);
    checkOutput("queue_empty_end", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
